// File: rtl/onehot_encode_pipe.sv
// Two-stage registered one-hot to binary encoder with valid/ready flow control.
// Optional build macro ONEHOT_ERR_CNT_EN adds saturating zero-hot/multi-hot counters.
module onehot_encode_pipe #(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned PRIORITY_LSB = 1,
    parameter int unsigned CNT_W        = 8,
    localparam int unsigned IDX_W       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_zero,
    output logic             out_multi
`ifdef ONEHOT_ERR_CNT_EN
    ,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] zero_cnt,
    output logic [CNT_W-1:0] multi_cnt
`endif
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_vec;
    logic             s2_adv;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_zero;
    logic             enc_multi;

    // S2 can take a new word when empty or draining this cycle
    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !rst && (!s1_valid || s2_adv);

    // Scan toward the winning end so the last hit is the priority bit
    always_comb begin
        enc_idx   = '0;
        enc_zero  = 1'b1;
        enc_multi = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            int j;
            j = (PRIORITY_LSB != 0) ? (int'(WIDTH) - 1 - i) : i;
            if (s1_vec[j]) begin
                if (!enc_zero) begin
                    enc_multi = 1'b1;
                end
                enc_zero = 1'b0;
                enc_idx  = IDX_W'(j);
            end
        end
    end

    // Stage 1: capture the raw request vector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_vec   <= '0;
        end else if (!s1_valid || s2_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_vec <= in_vec;
            end
        end
    end

    // Stage 2: encoded result, held while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_zero  <= 1'b0;
            out_multi <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_idx   <= enc_idx;
                out_zero  <= enc_zero;
                out_multi <= enc_multi;
            end
        end
    end

`ifdef ONEHOT_ERR_CNT_EN
    // Saturating error counters; clear wins over a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_cnt  <= '0;
            multi_cnt <= '0;
        end else if (cnt_clr) begin
            zero_cnt  <= '0;
            multi_cnt <= '0;
        end else if (out_valid && out_ready) begin
            if (out_zero && (zero_cnt != '1)) begin
                zero_cnt <= zero_cnt + CNT_W'(1);
            end
            if (out_multi && (multi_cnt != '1)) begin
                multi_cnt <= multi_cnt + CNT_W'(1);
            end
        end
    end
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_onehot_encode_pipe.sv
// Randomized scoreboard bench for onehot_encode_pipe at WIDTH=4 (LSB), WIDTH=5 (MSB), WIDTH=16.
// Counter checks are compiled in when ONEHOT_ERR_CNT_EN is defined.
module tb_onehot_encode_pipe;

    logic clk;
    logic rst;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_zero, a_out_multi;
    logic [3:0]  a_in_vec;
    logic [1:0]  a_out_idx;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_zero, b_out_multi;
    logic [4:0]  b_in_vec;
    logic [2:0]  b_out_idx;
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_zero, c_out_multi;
    logic [15:0] c_in_vec;
    logic [3:0]  c_out_idx;
`ifdef ONEHOT_ERR_CNT_EN
    logic        a_cnt_clr;
    logic [7:0]  a_zero_cnt, a_multi_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int q_a[$];
    int q_b[$];
    int q_c[$];
    bit prev_stall = 1'b0;
    int prev_out = 0;

    onehot_encode_pipe #(.WIDTH(4), .PRIORITY_LSB(1), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_vec(a_in_vec),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_idx(a_out_idx),
        .out_zero(a_out_zero), .out_multi(a_out_multi)
`ifdef ONEHOT_ERR_CNT_EN
        , .cnt_clr(a_cnt_clr), .zero_cnt(a_zero_cnt), .multi_cnt(a_multi_cnt)
`endif
    );

    onehot_encode_pipe #(.WIDTH(5), .PRIORITY_LSB(0), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_vec(b_in_vec),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_idx(b_out_idx),
        .out_zero(b_out_zero), .out_multi(b_out_multi)
`ifdef ONEHOT_ERR_CNT_EN
        , .cnt_clr(1'b0), .zero_cnt(), .multi_cnt()
`endif
    );

    onehot_encode_pipe #(.WIDTH(16), .PRIORITY_LSB(1), .CNT_W(8)) u_c (
        .clk(clk), .rst(rst),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_vec(c_in_vec),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_idx(c_out_idx),
        .out_zero(c_out_zero), .out_multi(c_out_multi)
`ifdef ONEHOT_ERR_CNT_EN
        , .cnt_clr(1'b0), .zero_cnt(), .multi_cnt()
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected result word: idx | zero<<8 | multi<<9, from set-bit count and position
    function automatic int ref_enc(input logic [15:0] v, input int w, input bit lsb);
        int n = 0;
        int lo = -1;
        int hi = -1;
        for (int i = 0; i < w; i++) begin
            if (v[i]) begin
                n++;
                if (lo < 0) lo = i;
                hi = i;
            end
        end
        if (n == 0) return 256;
        return (lsb ? lo : hi) + ((n > 1) ? 512 : 0);
    endfunction

    function automatic int pk(input int idx, input logic z, input logic m);
        return idx + (z ? 256 : 0) + (m ? 512 : 0);
    endfunction

    function automatic logic [15:0] rand_vec(input int w);
        logic [15:0] v;
        case ($urandom_range(0, 3))
            0:       v = '0;
            1, 2:    v = 16'(1) << $urandom_range(0, w - 1);
            default: v = 16'($urandom);
        endcase
        return v & ((16'(1) << w) - 16'(1) | ((w == 16) ? 16'hFFFF : 16'h0));
    endfunction

    // Scoreboard: transfers are decided by values stable across the negedge
    always @(negedge clk) begin
        if (rst) begin
            q_a.delete(); q_b.delete(); q_c.delete();
            prev_stall = 1'b0;
        end else begin
            if (a_out_valid && a_out_ready) begin
                if (q_a.size() == 0) check("a_spurious_out", 1, 0);
                else check("a_data", pk(int'(a_out_idx), a_out_zero, a_out_multi), q_a.pop_front());
            end
            if (a_in_valid && a_in_ready) q_a.push_back(ref_enc(16'(a_in_vec), 4, 1'b1));
            if (b_out_valid && b_out_ready) begin
                if (q_b.size() == 0) check("b_spurious_out", 1, 0);
                else check("b_data", pk(int'(b_out_idx), b_out_zero, b_out_multi), q_b.pop_front());
            end
            if (b_in_valid && b_in_ready) q_b.push_back(ref_enc(16'(b_in_vec), 5, 1'b0));
            if (c_out_valid && c_out_ready) begin
                if (q_c.size() == 0) check("c_spurious_out", 1, 0);
                else check("c_data", pk(int'(c_out_idx), c_out_zero, c_out_multi), q_c.pop_front());
            end
            if (c_in_valid && c_in_ready) q_c.push_back(ref_enc(c_in_vec, 16, 1'b1));
            if (prev_stall)
                check("a_stall_hold", pk(int'(a_out_idx), a_out_zero, a_out_multi), prev_out);
            prev_stall = a_out_valid && !a_out_ready;
            prev_out   = pk(int'(a_out_idx), a_out_zero, a_out_multi);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] words [6];
        int exp_out [6];
        int k;
        bit fire;

        words   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0110};
        exp_out = '{0, 1, 2, 3, 256, 1 + 512};
        rst = 1'b1;
        a_in_valid = 0; a_in_vec = '0; a_out_ready = 1;
        b_in_valid = 0; b_in_vec = '0; b_out_ready = 1;
        c_in_valid = 0; c_in_vec = '0; c_out_ready = 1;
`ifdef ONEHOT_ERR_CNT_EN
        a_cnt_clr = 0;
`endif
        repeat (3) step();
        check("rst_in_ready", int'(a_in_ready), 0);
        check("rst_out_valid", int'(a_out_valid), 0);
        check("rst_out_word", pk(int'(a_out_idx), a_out_zero, a_out_multi), 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", int'(a_in_ready), 1);

        // Two-cycle latency for a single one-hot word
        step();
        a_in_valid = 1; a_in_vec = 4'b0100;
        step();
        a_in_valid = 0;
        check("lat_cycle1_valid", int'(a_out_valid), 0);
        step();
        check("lat_cycle2_valid", int'(a_out_valid), 1);
        check("lat_cycle2_word", pk(int'(a_out_idx), a_out_zero, a_out_multi), 2);
        step();

        // Back-to-back stream incl. zero-hot and multi-hot words
        for (int c = 0; c <= 6; c++) begin
            a_in_valid = (c < 6);
            if (c < 6) a_in_vec = words[c];
            step();
            if (c >= 1) begin
                check("b2b_valid", int'(a_out_valid), 1);
                check("b2b_word", pk(int'(a_out_idx), a_out_zero, a_out_multi), exp_out[c - 1]);
            end
        end
        a_in_valid = 0;
        step(); step();

        // Backpressure: two accepts then in_ready low, then in-order drain
        a_out_ready = 0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            a_in_valid = 1; a_in_vec = words[k];
            #1 fire = a_in_ready;
            step();
            if (fire) k++;
        end
        check("stall_accepts", k, 2);
        check("stall_in_ready", int'(a_in_ready), 0);
        check("stall_out_word", pk(int'(a_out_idx), a_out_zero, a_out_multi), 0);
        a_out_ready = 1;
        for (int c = 0; c < 10 && k < 4; c++) begin
            a_in_vec = words[k];
            #1 fire = a_in_ready;
            step();
            if (fire) k++;
        end
        check("stall_all_accepted", k, 4);
        a_in_valid = 0;
        repeat (4) step();
        check("stall_drained", q_a.size(), 0);

        // Asynchronous reset with both stages full
        a_out_ready = 0;
        a_in_valid = 1; a_in_vec = 4'b0010;
        step();
        a_in_vec = 4'b1000;
        step();
        a_in_valid = 0;
        check("full_before_rst", int'(a_out_valid) + int'(!a_in_ready), 2);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_valid", int'(a_out_valid), 0);
        check("async_rst_in_ready", int'(a_in_ready), 0);
        step();
        rst = 1'b0;
        a_out_ready = 1;
        for (int c = 0; c < 4; c++) begin
            step();
            check("no_stale_after_rst", int'(a_out_valid), 0);
        end

        // Every single-bit position on the wide and non-power-of-2 instances
        for (int i = 0; i < 16; i++) begin
            c_in_valid = 1; c_in_vec = 16'(1) << i;
            b_in_valid = (i < 5); b_in_vec = 5'(1) << (i % 5);
            step();
        end
        b_in_valid = 1; b_in_vec = 5'b00110;
        c_in_valid = 0;
        step();
        b_in_valid = 0;
        repeat (4) step();

        // Randomized traffic on all instances
        for (int c = 0; c < 3000; c++) begin
            a_in_valid = $urandom_range(0, 3) != 0; a_in_vec = 4'(rand_vec(4));
            b_in_valid = $urandom_range(0, 3) != 0; b_in_vec = 5'(rand_vec(5));
            c_in_valid = $urandom_range(0, 3) != 0; c_in_vec = rand_vec(16);
            a_out_ready = $urandom_range(0, 2) != 0;
            b_out_ready = $urandom_range(0, 2) != 0;
            c_out_ready = $urandom_range(0, 1) != 0;
            step();
        end
        a_in_valid = 0; b_in_valid = 0; c_in_valid = 0;
        a_out_ready = 1; b_out_ready = 1; c_out_ready = 1;
        repeat (6) step();

`ifdef ONEHOT_ERR_CNT_EN
        a_cnt_clr = 1;
        step();
        a_cnt_clr = 0;
        a_in_valid = 1; a_in_vec = 4'b0000;
        repeat (300) step();
        a_in_valid = 0;
        repeat (3) step();
        check("zero_cnt_saturate", int'(a_zero_cnt), 255);
        a_in_valid = 1; a_in_vec = 4'b0110;
        step();
        a_in_valid = 0;
        repeat (3) step();
        check("multi_cnt_one", int'(a_multi_cnt), 1);
        a_out_ready = 0;
        a_in_valid = 1;
        step();
        a_in_valid = 0;
        repeat (3) step();
        a_cnt_clr = 1; a_out_ready = 1;
        step();
        a_cnt_clr = 0;
        check("clr_beats_incr_multi", int'(a_multi_cnt), 0);
        check("clr_zero_cnt", int'(a_zero_cnt), 0);
        repeat (3) step();
`endif

        check("a_final_drain", q_a.size(), 0);
        check("b_final_drain", q_b.size(), 0);
        check("c_final_drain", q_c.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
